// File: rtl/enclave_mem_pkg.sv
// Shared types and default sizes for the enclave SRAM arbiter slice.
package enclave_mem_pkg;

  localparam int unsigned MEM_ADDR_W = 8;
  localparam int unsigned MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACC_HOST = 2'd1,
    ST_ACC_CORE = 2'd2,
    ST_RESP     = 2'd3
  } arb_state_e;

endpackage

// File: rtl/enclave_sram_arbiter_if.sv
// Bus bundle between the arbiter (slave side) and host, core and SRAM (master side).
interface enclave_sram_arbiter_if
  import enclave_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W
);
  // Host: host_rd_i/host_wr_i are single-cycle pulses with no back-pressure.
  // Core: core_req_i (with we/addr/wdata) is held until the cycle core_gnt_o is
  // high; read data follows as a one-cycle core_rvalid_o the cycle after grant.
  logic              host_rd_i;
  logic              host_wr_i;
  logic [31:0]       host_addr_i;
  logic [DATA_W-1:0] host_wdata_i;
  logic [DATA_W-1:0] host_rdata_o;
  logic              host_busy_o;
  logic              host_ovf_o;
  logic              host_err_o;
  logic              core_req_i;
  logic              core_we_i;
  logic [ADDR_W-1:0] core_addr_i;
  logic [DATA_W-1:0] core_wdata_i;
  logic              core_gnt_o;
  logic              core_rvalid_o;
  logic [DATA_W-1:0] core_rdata_o;
  logic              sram_csb_o;
  logic              sram_web_o;
  logic [ADDR_W-1:0] sram_addr_o;
  logic [DATA_W-1:0] sram_din_o;
  logic [DATA_W-1:0] sram_dout_i;

  modport slave (
    input  host_rd_i, host_wr_i, host_addr_i, host_wdata_i,
    output host_rdata_o, host_busy_o, host_ovf_o, host_err_o,
    input  core_req_i, core_we_i, core_addr_i, core_wdata_i,
    output core_gnt_o, core_rvalid_o, core_rdata_o,
    output sram_csb_o, sram_web_o, sram_addr_o, sram_din_o,
    input  sram_dout_i
  );

  modport master (
    output host_rd_i, host_wr_i, host_addr_i, host_wdata_i,
    input  host_rdata_o, host_busy_o, host_ovf_o, host_err_o,
    output core_req_i, core_we_i, core_addr_i, core_wdata_i,
    input  core_gnt_o, core_rvalid_o, core_rdata_o,
    input  sram_csb_o, sram_web_o, sram_addr_o, sram_din_o,
    output sram_dout_i
  );
endinterface

// File: rtl/enclave_sram_arbiter_host_slot.sv
// One-entry host request buffer with sticky overflow and error flags.
module arb_host_slot
  import enclave_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rd_i,
  input  logic              wr_i,
  input  logic [31:0]       addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              consume_i,
  output logic              valid_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              ovf_o,
  output logic              err_o
);

  logic              valid_q, valid_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;
  logic              pulse, addr_ok, blocked, load;

  assign pulse   = rd_i | wr_i;
  assign addr_ok = ~|addr_i[31:ADDR_W];
  // A full slot still accepts a pulse when the arbiter drains it this cycle.
  assign blocked = valid_q & ~consume_i;
  assign load    = pulse & addr_ok & ~blocked;

  always_comb begin
    valid_d = load | (valid_q & ~consume_i);
    ovf_d   = ovf_q | (pulse & addr_ok & blocked);
    err_d   = err_q | (rd_i & wr_i) | (pulse & ~addr_ok);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      if (load) begin
        we_q    <= wr_i;
        addr_q  <= addr_i[ADDR_W-1:0];
        wdata_q <= wdata_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign we_o    = we_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign ovf_o   = ovf_q;
  assign err_o   = err_q;

endmodule

// File: rtl/enclave_sram_arbiter.sv
// Host/core arbiter for the enclave single-port SRAM.
// Optional core starvation guard: define ARB_STARVE_GUARD_EN.
module enclave_sram_arbiter
  import enclave_mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = MEM_ADDR_W,
  parameter int unsigned DATA_W   = MEM_DATA_W,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  enclave_sram_arbiter_if.slave  bus,
  output arb_state_e             dbg_state_o
);

  arb_state_e        state_q, state_d;
  logic              owner_core_q, owner_core_d;
  logic              csb_q, csb_d, web_q, web_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d, rdata_q, rdata_d;
  logic              slot_valid, slot_we, consume;
  logic [ADDR_W-1:0] slot_addr;
  logic [DATA_W-1:0] slot_wdata;
  logic              host_win, core_win, force_core;

  arb_host_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .rd_i      (bus.host_rd_i),
    .wr_i      (bus.host_wr_i),
    .addr_i    (bus.host_addr_i),
    .wdata_i   (bus.host_wdata_i),
    .consume_i (consume),
    .valid_o   (slot_valid),
    .we_o      (slot_we),
    .addr_o    (slot_addr),
    .wdata_o   (slot_wdata),
    .ovf_o     (bus.host_ovf_o),
    .err_o     (bus.host_err_o)
  );

  assign host_win = slot_valid & ~force_core;
  assign core_win = bus.core_req_i & ~host_win;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
  logic [CntW-1:0] wait_q, wait_d;

  assign force_core = bus.core_req_i & (wait_q >= CntW'(MAX_WAIT));

  always_comb begin
    wait_d = wait_q;
    if (state_q == ST_IDLE) begin
      if (core_win)
        wait_d = '0;
      else if (bus.core_req_i && host_win && wait_q != CntW'(MAX_WAIT))
        wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) wait_q <= '0;
    else          wait_q <= wait_d;
  end
`else
  assign force_core = 1'b0 && (MAX_WAIT > 0);
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      owner_core_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_core_q <= owner_core_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_core_d = owner_core_q;
    unique case (state_q)
      ST_IDLE: begin
        if (host_win) begin
          state_d      = ST_ACC_HOST;
          owner_core_d = 1'b0;
        end else if (core_win) begin
          state_d      = ST_ACC_CORE;
          owner_core_d = 1'b1;
        end
      end
      // web_q high means the access being driven is a read.
      ST_ACC_HOST, ST_ACC_CORE: state_d = web_q ? ST_RESP : ST_IDLE;
      ST_RESP:                  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    csb_d   = 1'b1;
    web_d   = 1'b1;
    addr_d  = addr_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    if (state_q == ST_IDLE && host_win) begin
      csb_d  = 1'b0;
      web_d  = ~slot_we;
      addr_d = slot_addr;
      din_d  = slot_wdata;
    end else if (state_q == ST_IDLE && core_win) begin
      csb_d  = 1'b0;
      web_d  = ~bus.core_we_i;
      addr_d = bus.core_addr_i;
      din_d  = bus.core_wdata_i;
    end
    if (state_q == ST_RESP && !owner_core_q) rdata_d = bus.sram_dout_i;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      addr_q  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
    end else begin
      csb_q   <= csb_d;
      web_q   <= web_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
    end
  end

  // Strobes are masked by reset so a read caught by reset is dropped, not returned.
  always_comb begin
    consume            = (state_q == ST_IDLE) & host_win;
    bus.core_gnt_o     = (state_q == ST_ACC_CORE) & ~wb_rst_i;
    bus.core_rvalid_o  = (state_q == ST_RESP) & owner_core_q & ~wb_rst_i;
    bus.core_rdata_o   = bus.core_rvalid_o ? bus.sram_dout_i : '0;
    bus.host_busy_o    = slot_valid | (state_q == ST_ACC_HOST) |
                         ((state_q == ST_RESP) & ~owner_core_q);
  end

  assign bus.host_rdata_o = rdata_q;
  assign bus.sram_csb_o   = csb_q;
  assign bus.sram_web_o   = web_q;
  assign bus.sram_addr_o  = addr_q;
  assign bus.sram_din_o   = din_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_enclave_sram_arbiter.sv
// Directed bench for enclave_sram_arbiter with an SRAM model and access scoreboard.
module tb_enclave_sram_arbiter;
  import enclave_mem_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  enclave_sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  arb_state_e dbg_state;

  enclave_sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // SRAM model: read data appears the cycle after the read is driven
  logic [DW-1:0] mem [0:255];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    bus.sram_dout_i = '0;
  end
  always @(posedge clk) begin
    if (bus.sram_csb_o === 1'b0) begin
      if (!bus.sram_web_o) mem[bus.sram_addr_o] <= bus.sram_din_o;
      else                 bus.sram_dout_i <= mem[bus.sram_addr_o];
    end
  end

  // scoreboard: expected SRAM accesses {we, addr, wdata}, in order
  logic [40:0] exp_q[$];
  always @(negedge clk) begin
    if (bus.sram_csb_o === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sram_access: unexpected access we=%0d addr=0x%0h, expected none",
                 !bus.sram_web_o, bus.sram_addr_o);
      end else begin
        logic [40:0] e;
        e = exp_q.pop_front();
        chk("sram_we_addr", {55'd0, !bus.sram_web_o, bus.sram_addr_o}, {55'd0, e[40:32]});
        if (e[40]) chk("sram_din", bus.sram_din_o, e[31:0]);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic core_access(input bit we, input logic [7:0] a, input logic [31:0] d);
    exp_q.push_back({we, a, we ? d : 32'h0});
    tick();
    bus.core_req_i = 1'b1; bus.core_we_i = we; bus.core_addr_i = a; bus.core_wdata_i = d;
    sample(); chk("core_gnt_idle", bus.core_gnt_o, 0);
    tick();
    sample(); chk("core_gnt", bus.core_gnt_o, 1); chk("core_rdata_idle", bus.core_rdata_o, 0);
    tick();
    bus.core_req_i = 1'b0; bus.core_we_i = 1'b0;
    sample();
    if (we) chk("core_gnt_after", bus.core_gnt_o, 0);
    else begin
      chk("core_rvalid", bus.core_rvalid_o, 1);
      chk("core_rdata", bus.core_rdata_o, d);
      tick();
    end
  endtask

  task automatic host_access(input bit we, input logic [7:0] a, input logic [31:0] d);
    exp_q.push_back({we, a, we ? d : 32'h0});
    tick();
    bus.host_wr_i = we; bus.host_rd_i = !we; bus.host_addr_i = {24'h0, a}; bus.host_wdata_i = d;
    tick();
    bus.host_wr_i = 1'b0; bus.host_rd_i = 1'b0;
    sample(); chk("host_busy_slot", bus.host_busy_o, 1);
    tick();
    sample(); chk("host_csb_acc", bus.sram_csb_o, 0);
    tick();
    sample(); chk("host_busy_n3", bus.host_busy_o, we ? 0 : 1);
    if (!we) begin
      tick();
      sample();
      chk("host_rdata", bus.host_rdata_o, d);
      chk("host_busy_done", bus.host_busy_o, 0);
    end
  endtask

  typedef struct {
    bit          host;
    bit          we;
    logic [7:0]  addr;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[11];
  int   gnt_c;
  int   exp_gnt_c;

  initial begin
    vecs[0]  = '{0, 1, 8'h05, 32'hA5A5A5A5};
    vecs[1]  = '{0, 0, 8'h05, 32'hA5A5A5A5};
    vecs[2]  = '{1, 1, 8'h10, 32'h12345678};
    vecs[3]  = '{1, 0, 8'h10, 32'h12345678};
    vecs[4]  = '{0, 1, 8'h20, 32'hDEADBEEF};
    vecs[5]  = '{1, 0, 8'h20, 32'hDEADBEEF};
    vecs[6]  = '{1, 1, 8'h30, 32'h0BADF00D};
    vecs[7]  = '{0, 0, 8'h30, 32'h0BADF00D};
    vecs[8]  = '{1, 1, 8'hFF, 32'hFFFFFFFF};
    vecs[9]  = '{0, 0, 8'hFF, 32'hFFFFFFFF};
    vecs[10] = '{0, 0, 8'h00, 32'h00000000};

    bus.host_rd_i = 0; bus.host_wr_i = 0; bus.host_addr_i = 0; bus.host_wdata_i = 0;
    bus.core_req_i = 0; bus.core_we_i = 0; bus.core_addr_i = 0; bus.core_wdata_i = 0;

    // reset values
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    sample();
    chk("rst_csb", bus.sram_csb_o, 1);
    chk("rst_web", bus.sram_web_o, 1);
    chk("rst_addr", bus.sram_addr_o, 0);
    chk("rst_din", bus.sram_din_o, 0);
    chk("rst_gnt", bus.core_gnt_o, 0);
    chk("rst_rvalid", bus.core_rvalid_o, 0);
    chk("rst_core_rdata", bus.core_rdata_o, 0);
    chk("rst_host_rdata", bus.host_rdata_o, 0);
    chk("rst_busy", bus.host_busy_o, 0);
    chk("rst_ovf", bus.host_ovf_o, 0);
    chk("rst_err", bus.host_err_o, 0);
    chk("rst_state", dbg_state, ST_IDLE);

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].host) host_access(vecs[i].we, vecs[i].addr, vecs[i].data);
      else              core_access(vecs[i].we, vecs[i].addr, vecs[i].data);
    end

    // core request held high while host reads arrive every 3 cycles
`ifdef ARB_STARVE_GUARD_EN
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 8'h10, 32'h0});
    exp_q.push_back({1'b1, 8'h40, 32'hC0C0C0C0});
    for (int i = 0; i < 2; i++) exp_q.push_back({1'b0, 8'h10, 32'h0});
    exp_gnt_c = 14;
`else
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, 8'h10, 32'h0});
    exp_q.push_back({1'b1, 8'h40, 32'hC0C0C0C0});
    exp_gnt_c = 20;
`endif
    gnt_c = -1;
    for (int c = 0; c < 40; c++) begin
      tick();
      bus.host_rd_i   = (c % 3 == 0) && (c < 18);
      bus.host_addr_i = 32'h10;
      bus.core_req_i  = (c >= 1) && (gnt_c < 0);
      bus.core_we_i   = 1'b1;
      bus.core_addr_i = 8'h40;
      bus.core_wdata_i = 32'hC0C0C0C0;
      sample();
      if (bus.core_gnt_o && gnt_c < 0) gnt_c = c;
    end
    bus.host_rd_i = 0; bus.core_req_i = 0; bus.core_we_i = 0;
    chk("starve_gnt_cycle", gnt_c, exp_gnt_c);
    chk("starve_host_rdata", bus.host_rdata_o, 32'h12345678);
    chk("starve_no_ovf", bus.host_ovf_o, 0);

    // second host pulse while the core holds the SRAM is dropped
    exp_q.push_back({1'b0, 8'h05, 32'h0});
    exp_q.push_back({1'b1, 8'h50, 32'h11111111});
    tick();
    bus.core_req_i = 1; bus.core_we_i = 0; bus.core_addr_i = 8'h05;
    tick();
    bus.core_req_i = 0;
    bus.host_wr_i = 1; bus.host_addr_i = 32'h50; bus.host_wdata_i = 32'h11111111;
    sample(); chk("ovf_core_gnt", bus.core_gnt_o, 1);
    tick();
    bus.host_addr_i = 32'h51; bus.host_wdata_i = 32'h22222222;
    sample();
    chk("ovf_core_rvalid", bus.core_rvalid_o, 1);
    chk("ovf_core_rdata", bus.core_rdata_o, 32'hA5A5A5A5);
    tick();
    bus.host_wr_i = 0;
    sample();
    chk("ovf_flag", bus.host_ovf_o, 1);
    chk("ovf_busy", bus.host_busy_o, 1);
    repeat (4) tick();

    // out-of-range host address
    sample(); chk("err_before", bus.host_err_o, 0);
    tick();
    bus.host_rd_i = 1; bus.host_addr_i = 32'h100;
    tick();
    bus.host_rd_i = 0;
    sample();
    chk("err_addr_flag", bus.host_err_o, 1);
    chk("err_addr_busy", bus.host_busy_o, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      sample(); chk("err_addr_csb", bus.sram_csb_o, 1);
    end

    // reset during RESP of a core read
    exp_q.push_back({1'b0, 8'h05, 32'h0});
    tick();
    bus.core_req_i = 1; bus.core_we_i = 0; bus.core_addr_i = 8'h05;
    tick();
    bus.core_req_i = 0;
    sample(); chk("rresp_gnt", bus.core_gnt_o, 1);
    tick();
    rst = 1'b1;
    sample();
    chk("rresp_state", dbg_state, ST_RESP);
    chk("rresp_no_rvalid", bus.core_rvalid_o, 0);
    chk("rresp_rdata", bus.core_rdata_o, 0);
    tick();
    rst = 1'b0;
    sample();
    chk("rresp_csb", bus.sram_csb_o, 1);
    chk("rresp_ovf", bus.host_ovf_o, 0);
    chk("rresp_err", bus.host_err_o, 0);
    chk("rresp_busy", bus.host_busy_o, 0);
    chk("rresp_host_rdata", bus.host_rdata_o, 0);
    chk("rresp_idle", dbg_state, ST_IDLE);

    // rd and wr together: executed as a write, error flagged
    exp_q.push_back({1'b1, 8'h02, 32'h00000077});
    tick();
    bus.host_rd_i = 1; bus.host_wr_i = 1; bus.host_addr_i = 32'h02; bus.host_wdata_i = 32'h77;
    tick();
    bus.host_rd_i = 0; bus.host_wr_i = 0;
    sample(); chk("both_err", bus.host_err_o, 1);
    repeat (3) tick();
    core_access(1'b0, 8'h02, 32'h00000077);

    repeat (3) tick();
    chk("exp_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
